// File: rtl/pipe_dp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_dp_pkg
// Description : Shared types and constants for the two-stage datapath:
//               ALU opcode enum, default sizes, WB stage record, ALU helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_dp_pkg;

  localparam int unsigned DW_DEF  = 16;
  localparam int unsigned RN_DEF  = 16;
  localparam int unsigned MD_DEF  = 256;
  localparam int unsigned RAW_DEF = $clog2(RN_DEF);

  typedef enum logic [2:0] {
    ALU_PASS_A = 3'd0,
    ALU_ADD    = 3'd1,
    ALU_SUB    = 3'd2,
    ALU_AND    = 3'd3,
    ALU_OR     = 3'd4,
    ALU_XOR    = 3'd5,
    ALU_NOT_A  = 3'd6,
    ALU_ZERO   = 3'd7
  } alu_op_e;

  // WB stage record. Fields are sized for the default configuration, which is
  // also the largest supported one; narrower instances use the low bits and
  // leave the rest at zero.
  typedef struct packed {
    logic               valid;
    logic               w_en;
    logic               rf_s;
    logic [RAW_DEF-1:0] w_addr;
    logic [DW_DEF-1:0]  alu;
  } wb_stage_t;

  // Every operation is modulo 2^n, so evaluating at full width and keeping the
  // low DW bits gives the correct narrow result.
  function automatic logic [DW_DEF-1:0] alu_eval(
    input alu_op_e           op,
    input logic [DW_DEF-1:0] a,
    input logic [DW_DEF-1:0] b
  );
    logic [DW_DEF-1:0] r;
    case (op)
      ALU_PASS_A: r = a;
      ALU_ADD:    r = a + b;
      ALU_SUB:    r = a - b;
      ALU_AND:    r = a & b;
      ALU_OR:     r = a | b;
      ALU_XOR:    r = a ^ b;
      ALU_NOT_A:  r = ~a;
      default:    r = '0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dp_ram.sv
`default_nettype none
// ============================================================================
// Module      : dp_ram
// Description : Single-port data memory, synchronous read with one cycle of
//               latency, write-first on a same-address read/write.
// Revision    : 1.0 - initial release
// ============================================================================
module dp_ram #(
  parameter  int unsigned DW  = 16,
  parameter  int unsigned MD  = 256,
  localparam int unsigned MAW = $clog2(MD)
) (
  input  logic           Clk,
  input  logic           we_i,
  input  logic [MAW-1:0] addr_i,
  input  logic [DW-1:0]  wdata_i,
  output logic [DW-1:0]  rdata_o
);

  logic [DW-1:0] mem_q [MD];
  logic [DW-1:0] rdata_q;

  // Array write plus registered read; the write data bypasses to the read port.
  always_ff @(posedge Clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
      rdata_q       <= wdata_i;
    end else begin
      rdata_q       <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/pipe_datapath.sv
`default_nettype none
// ============================================================================
// Module      : pipe_datapath
// Description : Two-stage (EX, WB) register-file / ALU / memory datapath with
//               full WB->EX operand forwarding, so dependent operations issue
//               back to back without stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_datapath
  import pipe_dp_pkg::*;
#(
  parameter  int unsigned DW  = DW_DEF,
  parameter  int unsigned RN  = RN_DEF,
  parameter  int unsigned MD  = MD_DEF,
  localparam int unsigned RAW = $clog2(RN),
  localparam int unsigned MAW = $clog2(MD)
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           In_valid,
  input  logic           D_wr,
  input  logic           RF_W_en,
  input  logic           RF_s,
  input  logic [MAW-1:0] D_Addr,
  input  logic [RAW-1:0] RF_W_addr,
  input  logic [RAW-1:0] RF_Ra_addr,
  input  logic [RAW-1:0] RF_Rb_addr,
  input  logic [2:0]     Alu_s0,
  output logic [DW-1:0]  A,
  output logic [DW-1:0]  B,
  output logic [DW-1:0]  ALU_Out,
  output logic [DW-1:0]  W_data,
  output logic           Out_valid
);

  alu_op_e           op_w;
  logic [DW-1:0]     rf_q [RN];
  logic [DW-1:0]     rf_a_w;
  logic [DW-1:0]     rf_b_w;
  logic              wb_live_w;
  logic              fwd_a_w;
  logic              fwd_b_w;
  logic              rf_we_w;
  logic              mem_we_w;
  logic [DW_DEF-1:0] alu_full_w;
  logic [DW-1:0]     alu_res_w;
  logic [DW-1:0]     mem_rdata_w;
  wb_stage_t         wb_d;
  wb_stage_t         wb_q;

  assign op_w = alu_op_e'(Alu_s0);

  // ---------------------------------------------------------------------------
  // EX stage: operand read with forwarding from the WB entry
  // ---------------------------------------------------------------------------
  assign rf_a_w    = rf_q[RF_Ra_addr];
  assign rf_b_w    = rf_q[RF_Rb_addr];
  assign wb_live_w = wb_q.valid & wb_q.w_en;
  assign fwd_a_w   = wb_live_w & (wb_q.w_addr[RAW-1:0] == RF_Ra_addr);
  assign fwd_b_w   = wb_live_w & (wb_q.w_addr[RAW-1:0] == RF_Rb_addr);

  assign A = fwd_a_w ? W_data : rf_a_w;
  assign B = fwd_b_w ? W_data : rf_b_w;

  assign alu_full_w = alu_eval(op_w, DW_DEF'(A), DW_DEF'(B));
  assign alu_res_w  = alu_full_w[DW-1:0];

  // Reset blocks any store, including one issued in the reset cycle.
  assign mem_we_w = In_valid & D_wr & ~Reset;

  dp_ram #(
    .DW (DW),
    .MD (MD)
  ) u_ram (
    .Clk     (Clk),
    .we_i    (mem_we_w),
    .addr_i  (D_Addr),
    .wdata_i (A),
    .rdata_o (mem_rdata_w)
  );

  // Assemble the EX->WB record; a bubble still travels but with valid low.
  always_comb begin
    wb_d                    = '0;
    wb_d.valid              = In_valid;
    wb_d.w_en               = RF_W_en;
    wb_d.rf_s               = RF_s;
    wb_d.w_addr[RAW-1:0]    = RF_W_addr;
    wb_d.alu[DW-1:0]        = alu_res_w;
  end

  // EX->WB stage register, cleared by reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
    end
  end

  // ---------------------------------------------------------------------------
  // WB stage: source select and register write
  // ---------------------------------------------------------------------------
  assign W_data    = wb_q.rf_s ? mem_rdata_w : wb_q.alu[DW-1:0];
  assign ALU_Out   = wb_q.alu[DW-1:0];
  assign Out_valid = wb_q.valid;
  assign rf_we_w   = wb_live_w & ~Reset;

  // Register file: cleared by reset, written from the WB entry otherwise.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < int'(RN); i++) begin
        rf_q[i] <= '0;
      end
    end else if (rf_we_w) begin
      rf_q[wb_q.w_addr[RAW-1:0]] <= W_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_datapath
// Description : Self-checking bench for pipe_datapath. An architectural model
//               (sequential register/memory semantics) predicts operands and
//               writeback results; expectations queue until the WB stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_datapath;

  logic        Clk = 1'b0;
  logic        Reset, In_valid, D_wr, RF_W_en, RF_s;
  logic [7:0]  D_Addr;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr;
  logic [2:0]  Alu_s0;
  logic [15:0] A, B, ALU_Out, W_data;
  logic        Out_valid;

  // Narrow instance for the wrap check at DW=8
  logic        s_Reset, s_In_valid, s_D_wr, s_RF_W_en, s_RF_s;
  logic [5:0]  s_D_Addr;
  logic [2:0]  s_RF_W_addr, s_RF_Ra_addr, s_RF_Rb_addr;
  logic [2:0]  s_Alu_s0;
  logic [7:0]  s_A, s_B, s_ALU_Out, s_W_data;
  logic        s_Out_valid;

  always #5 Clk = ~Clk;

  pipe_datapath u_dut (
    .Clk(Clk), .Reset(Reset), .In_valid(In_valid), .D_wr(D_wr),
    .RF_W_en(RF_W_en), .RF_s(RF_s), .D_Addr(D_Addr), .RF_W_addr(RF_W_addr),
    .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr), .Alu_s0(Alu_s0),
    .A(A), .B(B), .ALU_Out(ALU_Out), .W_data(W_data), .Out_valid(Out_valid)
  );

  pipe_datapath #(.DW(8), .RN(8), .MD(64)) u_dut8 (
    .Clk(Clk), .Reset(s_Reset), .In_valid(s_In_valid), .D_wr(s_D_wr),
    .RF_W_en(s_RF_W_en), .RF_s(s_RF_s), .D_Addr(s_D_Addr), .RF_W_addr(s_RF_W_addr),
    .RF_Ra_addr(s_RF_Ra_addr), .RF_Rb_addr(s_RF_Rb_addr), .Alu_s0(s_Alu_s0),
    .A(s_A), .B(s_B), .ALU_Out(s_ALU_Out), .W_data(s_W_data), .Out_valid(s_Out_valid)
  );

  typedef struct {
    logic        v;
    logic [15:0] alu;
    logic [15:0] wd;
    bit          full;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] m_rf [16];
  logic [15:0] m_mem [256];
  int          checks   = 0;
  int          failures = 0;

  // One issue cycle: drive at posedge+1, check at negedge, update model.
  task automatic cycle(input logic v, input logic dwr, input logic wen, input logic rfs,
                       input logic [7:0] da, input logic [3:0] wa, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [2:0] op);
    logic [15:0] ea, eb, ealu, ewd;
    exp_t e;
    In_valid = v; D_wr = dwr; RF_W_en = wen; RF_s = rfs; D_Addr = da;
    RF_W_addr = wa; RF_Ra_addr = ra; RF_Rb_addr = rb; Alu_s0 = op;
    ea = m_rf[ra];
    eb = m_rf[rb];
    case (op)
      3'd0: ealu = ea;
      3'd1: ealu = ea + eb;
      3'd2: ealu = ea - eb;
      3'd3: ealu = ea & eb;
      3'd4: ealu = ea | eb;
      3'd5: ealu = ea ^ eb;
      3'd6: ealu = ~ea;
      default: ealu = 16'h0000;
    endcase
    @(negedge Clk);
    checks++;
    if (A !== ea) begin failures++; $display("FAIL operand_A: got %h expected %h (ra=%0d)", A, ea, ra); end
    checks++;
    if (B !== eb) begin failures++; $display("FAIL operand_B: got %h expected %h (rb=%0d)", B, eb, rb); end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (Out_valid !== e.v) begin failures++; $display("FAIL out_valid: got %b expected %b", Out_valid, e.v); end
      if (e.full) begin
        checks++;
        if (ALU_Out !== e.alu) begin failures++; $display("FAIL alu_out: got %h expected %h", ALU_Out, e.alu); end
        checks++;
        if (W_data !== e.wd) begin failures++; $display("FAIL w_data: got %h expected %h", W_data, e.wd); end
      end
    end
    ewd = ealu;
    if (v) begin
      if (dwr) m_mem[da] = ea;
      if (rfs) ewd = m_mem[da];
      if (wen) m_rf[wa] = ewd;
    end
    e.v = v; e.alu = ealu; e.wd = ewd; e.full = v;
    sb_q.push_back(e);
    @(posedge Clk); #1;
  endtask

  // Two reset cycles with a store+writeback driven that must be ignored.
  task automatic do_reset();
    exp_t e;
    Reset = 1'b1; In_valid = 1'b1; D_wr = 1'b1; RF_W_en = 1'b1; RF_s = 1'b0;
    D_Addr = 8'd9; RF_W_addr = 4'd5; RF_Ra_addr = 4'd2; RF_Rb_addr = 4'd2; Alu_s0 = 3'd1;
    repeat (2) begin @(posedge Clk); #1; end
    Reset = 1'b0; In_valid = 1'b0; D_wr = 1'b0; RF_W_en = 1'b0;
    sb_q.delete();
    for (int i = 0; i < 16; i++) m_rf[i] = 16'h0000;
    e.v = 1'b0; e.alu = 16'h0000; e.wd = 16'h0000; e.full = 1'b1;
    sb_q.push_back(e);
  endtask

  task automatic read_all_regs();
    for (int i = 0; i < 16; i++) cycle(0, 0, 0, 0, 8'd0, 4'd0, 4'(i), 4'(15 - i), 3'd0);
  endtask

  task automatic test_reset();
    do_reset();
    read_all_regs();
  endtask

  // Build 5 and 3 from R0 with the ALU, store them, and check the 16-bit wrap.
  task automatic test_preload();
    cycle(1, 0, 1, 0, 8'd0, 4'd1, 4'd0, 4'd0, 3'd6);
    cycle(1, 0, 1, 0, 8'd0, 4'd2, 4'd1, 4'd1, 3'd1);
    cycle(1, 0, 1, 0, 8'd0, 4'd3, 4'd1, 4'd2, 3'd5);
    cycle(1, 0, 1, 0, 8'd0, 4'd4, 4'd3, 4'd3, 3'd1);
    cycle(1, 0, 1, 0, 8'd0, 4'd5, 4'd4, 4'd4, 3'd1);
    cycle(1, 0, 1, 0, 8'd0, 4'd6, 4'd5, 4'd3, 3'd1);
    cycle(1, 0, 1, 0, 8'd0, 4'd7, 4'd4, 4'd3, 3'd1);
    cycle(1, 0, 1, 0, 8'd0, 4'd8, 4'd1, 4'd3, 3'd1);
    checks++;
    if (ALU_Out !== 16'h0000) begin failures++; $display("FAIL add_wrap16: got %h expected 0000", ALU_Out); end
    cycle(1, 1, 0, 0, 8'd20, 4'd0, 4'd6, 4'd0, 3'd0);
    cycle(1, 1, 0, 0, 8'd21, 4'd0, 4'd7, 4'd0, 3'd0);
    cycle(0, 0, 0, 0, 8'd0, 4'd0, 4'd0, 4'd0, 3'd0);
    do_reset();
  endtask

  task automatic test_load();
    cycle(0, 0, 0, 0, 8'd0, 4'd0, 4'd0, 4'd0, 3'd0);
    cycle(1, 0, 1, 1, 8'd20, 4'd1, 4'd0, 4'd0, 3'd0);
    cycle(1, 0, 1, 1, 8'd21, 4'd2, 4'd0, 4'd0, 3'd0);
    cycle(0, 0, 0, 0, 8'd0, 4'd0, 4'd1, 4'd2, 3'd0);
    cycle(0, 0, 0, 0, 8'd0, 4'd0, 4'd1, 4'd2, 3'd0);
    checks++;
    if (A !== 16'h0005) begin failures++; $display("FAIL load_R1: got %h expected 0005", A); end
    checks++;
    if (B !== 16'h0003) begin failures++; $display("FAIL load_R2: got %h expected 0003", B); end
  endtask

  task automatic test_back_to_back();
    cycle(1, 0, 1, 0, 8'd0, 4'd3, 4'd1, 4'd2, 3'd1);
    checks++;
    if (ALU_Out !== 16'h0008) begin failures++; $display("FAIL b2b_add: got %h expected 0008", ALU_Out); end
    cycle(1, 0, 1, 0, 8'd0, 4'd4, 4'd3, 4'd2, 3'd2);
    checks++;
    if (ALU_Out !== 16'h0005) begin failures++; $display("FAIL b2b_sub: got %h expected 0005", ALU_Out); end
    cycle(0, 0, 0, 0, 8'd0, 4'd0, 4'd3, 4'd4, 3'd0);
  endtask

  task automatic test_store_load();
    cycle(1, 1, 0, 0, 8'd9, 4'd0, 4'd1, 4'd0, 3'd0);
    cycle(1, 0, 1, 1, 8'd9, 4'd5, 4'd0, 4'd0, 3'd0);
    checks++;
    if (W_data !== 16'h0005) begin failures++; $display("FAIL store_load: got %h expected 0005", W_data); end
    cycle(1, 1, 1, 1, 8'd10, 4'd6, 4'd2, 4'd0, 3'd0);
    checks++;
    if (W_data !== 16'h0003) begin failures++; $display("FAIL rd_during_wr: got %h expected 0003", W_data); end
    cycle(0, 0, 0, 0, 8'd0, 4'd0, 4'd5, 4'd6, 3'd0);
  endtask

  task automatic test_bubble();
    cycle(0, 1, 1, 0, 8'd9, 4'd1, 4'd2, 4'd0, 3'd7);
    checks++;
    if (Out_valid !== 1'b0) begin failures++; $display("FAIL bubble_valid: got %b expected 0", Out_valid); end
    cycle(1, 0, 1, 1, 8'd9, 4'd7, 4'd1, 4'd0, 3'd0);
    checks++;
    if (W_data !== 16'h0005) begin failures++; $display("FAIL bubble_mem: got %h expected 0005", W_data); end
    cycle(0, 0, 0, 0, 8'd0, 4'd0, 4'd1, 4'd7, 3'd0);
  endtask

  task automatic test_reset_inflight();
    cycle(1, 0, 1, 0, 8'd0, 4'd9, 4'd1, 4'd2, 3'd1);
    do_reset();
    read_all_regs();
    cycle(1, 0, 1, 1, 8'd9, 4'd3, 4'd0, 4'd0, 3'd0);
    checks++;
    if (W_data !== 16'h0005) begin failures++; $display("FAIL reset_mem_kept: got %h expected 0005", W_data); end
    cycle(0, 0, 0, 0, 8'd0, 4'd0, 4'd3, 4'd9, 3'd0);
  endtask

  // DW=8: R1=~R0 (FF), R2=R1+R1 (FE), R3=R1^R2 (01), R4=R1+R3 wraps to 00.
  task automatic test_dw8();
    logic [7:0] exp8;
    s_Reset = 1'b1;
    repeat (2) begin @(posedge Clk); #1; end
    s_Reset = 1'b0;
    checks++;
    if (s_Out_valid !== 1'b0) begin failures++; $display("FAIL dw8_reset_valid: got %b expected 0", s_Out_valid); end
    for (int k = 0; k < 4; k++) begin
      s_In_valid = 1'b1; s_RF_W_en = 1'b1;
      case (k)
        0: begin s_Alu_s0 = 3'd6; s_RF_Ra_addr = 3'd0; s_RF_Rb_addr = 3'd0; s_RF_W_addr = 3'd1; exp8 = 8'hFF; end
        1: begin s_Alu_s0 = 3'd1; s_RF_Ra_addr = 3'd1; s_RF_Rb_addr = 3'd1; s_RF_W_addr = 3'd2; exp8 = 8'hFE; end
        2: begin s_Alu_s0 = 3'd5; s_RF_Ra_addr = 3'd1; s_RF_Rb_addr = 3'd2; s_RF_W_addr = 3'd3; exp8 = 8'h01; end
        default: begin s_Alu_s0 = 3'd1; s_RF_Ra_addr = 3'd1; s_RF_Rb_addr = 3'd3; s_RF_W_addr = 3'd4; exp8 = 8'h00; end
      endcase
      @(posedge Clk); #1;
      checks++;
      if (s_ALU_Out !== exp8) begin failures++; $display("FAIL dw8_alu_%0d: got %h expected %h", k, s_ALU_Out, exp8); end
      checks++;
      if (s_Out_valid !== 1'b1) begin failures++; $display("FAIL dw8_valid_%0d: got %b expected 1", k, s_Out_valid); end
    end
    s_In_valid = 1'b0; s_RF_W_en = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; In_valid = 1'b0; D_wr = 1'b0; RF_W_en = 1'b0; RF_s = 1'b0;
    D_Addr = '0; RF_W_addr = '0; RF_Ra_addr = '0; RF_Rb_addr = '0; Alu_s0 = '0;
    s_Reset = 1'b1; s_In_valid = 1'b0; s_D_wr = 1'b0; s_RF_W_en = 1'b0; s_RF_s = 1'b0;
    s_D_Addr = '0; s_RF_W_addr = '0; s_RF_Ra_addr = '0; s_RF_Rb_addr = '0; s_Alu_s0 = '0;
    for (int i = 0; i < 16; i++) m_rf[i] = 16'h0000;
    @(posedge Clk); #1;
    test_reset();
    test_preload();
    test_load();
    test_back_to_back();
    test_store_load();
    test_bubble();
    test_reset_inflight();
    test_dw8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
